// File: rtl/tc_countdown_timer_pkg.sv
// State encodings shared by the timer components of the library.
package tc_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tc_countdown_timer.sv
// Down-counting reload timer with one-shot and periodic modes.
// The value output is a one-cycle registered copy of the internal count.
module tc_countdown_timer
  import tc_countdown_timer_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int STEP      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] in,
  input  logic                 periodic,
  input  logic                 enable,
  input  logic                 stop,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 tick,
  output logic                 busy,
  output logic                 done
);

  localparam logic [BIT_WIDTH-1:0] STEP_V = BIT_WIDTH'(STEP);

  state_t               state;
  logic [BIT_WIDTH-1:0] value;
  logic [BIT_WIDTH-1:0] reload;
  logic                 mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      value  <= '0;
      reload <= '0;
      mode   <= 1'b0;
      out    <= '0;
      tick   <= 1'b0;
    end else begin
      out  <= value;
      tick <= 1'b0;
      if (stop) begin
        // Abort keeps the programmed period and mode for a later inspection.
        value <= '0;
        state <= ST_IDLE;
      end else if (load) begin
        value  <= in;
        reload <= in;
        mode   <= periodic;
        if (in != '0) begin
          state <= ST_RUN;
        end else begin
          // A zero period expires at once and never auto-reloads.
          state <= ST_DONE;
          tick  <= 1'b1;
        end
      end else begin
        case (state)
          ST_RUN: begin
            if (enable) begin
              if (value > STEP_V) begin
                value <= value - STEP_V;
              end else begin
                tick <= 1'b1;
                if (mode) begin
                  value <= reload;
                end else begin
                  value <= '0;
                  state <= ST_DONE;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_tc_countdown_timer.sv
// Bench for tc_countdown_timer: constant-vector table, hand corner cases and
// randomized traffic compared against a behavioural timer model (STEP 1 and 3).
module tb_tc_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] in = '0;
  logic       periodic = 1'b0;
  logic       enable = 1'b0;
  logic       stop = 1'b0;

  logic [7:0] out_a, out_b;
  logic       tick_a, tick_b, busy_a, busy_b, done_a, done_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tc_countdown_timer #(.BIT_WIDTH(8), .STEP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .in(in), .periodic(periodic),
    .enable(enable), .stop(stop), .out(out_a), .tick(tick_a), .busy(busy_a), .done(done_a)
  );

  tc_countdown_timer #(.BIT_WIDTH(8), .STEP(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .in(in), .periodic(periodic),
    .enable(enable), .stop(stop), .out(out_b), .tick(tick_b), .busy(busy_b), .done(done_b)
  );

  // Behavioural model: remaining count plus a phase name per instance.
  int    m_left[2];
  int    m_period[2];
  bit    m_auto[2];
  string m_phase[2];
  int    m_out[2];
  bit    m_tick[2];
  int    m_step[2] = '{1, 3};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_period[k] = 0; m_auto[k] = 0;
      m_phase[k] = "idle"; m_out[k] = 0; m_tick[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = m_left[k];
      m_tick[k] = 0;
      if (stop) begin
        m_left[k] = 0;
        m_phase[k] = "idle";
      end else if (load) begin
        m_left[k] = int'(in);
        m_period[k] = int'(in);
        m_auto[k] = periodic;
        if (in == 0) begin
          m_phase[k] = "done";
          m_tick[k] = 1;
        end else begin
          m_phase[k] = "run";
        end
      end else if (m_phase[k] == "run" && enable) begin
        if (m_left[k] - m_step[k] > 0) begin
          m_left[k] = m_left[k] - m_step[k];
        end else begin
          m_tick[k] = 1;
          if (m_auto[k]) m_left[k] = m_period[k];
          else begin
            m_left[k] = 0;
            m_phase[k] = "done";
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " a.out"},  int'(out_a),  m_out[0]);
    chk({tag, " a.tick"}, int'(tick_a), int'(m_tick[0]));
    chk({tag, " a.busy"}, int'(busy_a), int'(m_phase[0] == "run"));
    chk({tag, " a.done"}, int'(done_a), int'(m_phase[0] == "done"));
    chk({tag, " b.out"},  int'(out_b),  m_out[1]);
    chk({tag, " b.tick"}, int'(tick_b), int'(m_tick[1]));
    chk({tag, " b.busy"}, int'(busy_b), int'(m_phase[1] == "run"));
    chk({tag, " b.done"}, int'(done_b), int'(m_phase[1] == "done"));
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic drive(input bit l, input int v, input bit p, input bit e, input bit s);
    load = l; in = 8'(v); periodic = p; enable = e; stop = s;
  endtask

  typedef struct {
    bit l; int v; bit p; bit e; bit s;
    int eo; bit et; bit eb; bit ed;
  } vec_t;

  vec_t vecs[29];

  initial begin
    vecs = '{
      '{1, 3, 0, 1, 0,  0, 0, 1, 0},   // one-shot period 3
      '{0, 0, 0, 1, 0,  3, 0, 1, 0},
      '{0, 0, 0, 1, 0,  2, 0, 1, 0},
      '{0, 0, 0, 1, 0,  1, 1, 0, 1},
      '{0, 0, 0, 1, 0,  0, 0, 0, 1},
      '{1, 2, 1, 1, 0,  0, 0, 1, 0},   // periodic period 2
      '{0, 0, 0, 1, 0,  2, 0, 1, 0},
      '{0, 0, 0, 1, 0,  1, 1, 1, 0},
      '{0, 0, 0, 1, 0,  2, 0, 1, 0},
      '{0, 0, 0, 1, 0,  1, 1, 1, 0},
      '{1, 0, 1, 1, 0,  2, 1, 0, 1},   // zero period with periodic=1
      '{0, 0, 0, 1, 0,  0, 0, 0, 1},
      '{1, 9, 0, 1, 1,  0, 0, 0, 0},   // stop beats load
      '{0, 0, 0, 1, 0,  0, 0, 0, 0},
      '{1, 7, 0, 1, 0,  0, 0, 1, 0},   // enable hold at 5
      '{0, 0, 0, 1, 0,  7, 0, 1, 0},
      '{0, 0, 0, 1, 0,  6, 0, 1, 0},
      '{0, 0, 0, 0, 0,  5, 0, 1, 0},
      '{0, 0, 0, 0, 0,  5, 0, 1, 0},
      '{0, 0, 0, 0, 0,  5, 0, 1, 0},
      '{0, 0, 0, 0, 0,  5, 0, 1, 0},
      '{0, 0, 0, 0, 0,  5, 0, 1, 0},
      '{0, 0, 0, 1, 0,  5, 0, 1, 0},
      '{0, 0, 0, 1, 0,  4, 0, 1, 0},
      '{0, 0, 0, 1, 0,  3, 0, 1, 0},
      '{0, 0, 0, 1, 0,  2, 0, 1, 0},
      '{1, 4, 0, 1, 0,  1, 0, 1, 0},   // load on expiry edge: no tick
      '{0, 0, 0, 1, 1,  4, 0, 0, 0},   // stop
      '{0, 0, 0, 1, 0,  0, 0, 0, 0}
    };

    model_reset();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("reset out",  int'(out_a),  0);
    chk("reset tick", int'(tick_a), 0);
    chk("reset busy", int'(busy_a), 0);
    chk("reset done", int'(done_a), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < $size(vecs); i++) begin
      drive(vecs[i].l, vecs[i].v, vecs[i].p, vecs[i].e, vecs[i].s);
      step();
      $display("vec %0d: out=%0d tick=%0b busy=%0b done=%0b", i, out_a, tick_a, busy_a, done_a);
      chk($sformatf("vec%0d out", i),  int'(out_a),  vecs[i].eo);
      chk($sformatf("vec%0d tick", i), int'(tick_a), int'(vecs[i].et));
      chk($sformatf("vec%0d busy", i), int'(busy_a), int'(vecs[i].eb));
      chk($sformatf("vec%0d done", i), int'(done_a), int'(vecs[i].ed));
      chk_model($sformatf("vec%0d", i));
    end

    // STEP = 3, period 7: 7 -> 4 -> 1 -> expiry on the 3rd enabled edge.
    drive(1, 7, 0, 1, 0);
    step();
    drive(0, 0, 0, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      $display("step3 edge %0d: out=%0d tick=%0b", i, out_b, tick_b);
      chk($sformatf("step3 tick e%0d", i), int'(tick_b), int'(i == 3));
      chk_model($sformatf("step3 e%0d", i));
    end
    chk("step3 done", int'(done_b), 1);

    // Asynchronous reset between edges during a count.
    drive(1, 20, 1, 1, 0);
    step();
    drive(0, 0, 0, 1, 0);
    repeat (3) step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    $display("async reset: out=%0d tick=%0b busy=%0b done=%0b", out_a, tick_a, busy_a, done_a);
    chk("arst out",  int'(out_a),  0);
    chk("arst busy", int'(busy_a), 0);
    chk("arst done", int'(done_a), 0);
    chk("arst tick", int'(tick_a), 0);
    chk("arst b.busy", int'(busy_b), 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post-rst out %0d", i), int'(out_a), 0);
      chk($sformatf("post-rst busy %0d", i), int'(busy_a), 0);
      chk_model($sformatf("post-rst %0d", i));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit l, s;
      int v;
      l = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      drive(l, v, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), s);
      step();
      $display("rnd %0d: ld=%0b in=%0d st=%0b en=%0b | a out=%0d tick=%0b | b out=%0d tick=%0b",
               i, l, v, s, enable, out_a, tick_a, out_b, tick_b);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
